// File: rtl/cm_sdp_ram_pkg.sv
// rtl/cm_sdp_ram_pkg.sv - shared types and helpers for the simple-dual-port RAM responder
//
// Contents:
//   state_t   : sequencer state encoding (ST_INIT, ST_READY)
//   PAR_MAX_W : widest word the parity helper accepts
//   even_par  : even parity over the low 'width' bits of a word
package cm_sdp_ram_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int PAR_MAX_W = 64;

  // Callers zero-extend to PAR_MAX_W; bits at or above 'width' are ignored.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d, input int width);
    logic p;
    p = 1'b0;
    for (int i = 0; i < PAR_MAX_W; i++) begin
      if (i < width) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/cm_sdp_ram_init_seq.sv
// rtl/cm_sdp_ram_init_seq.sv - zero-fill sequencer for the RAM responder
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear, restarts the fill from address 0
//   init_busy  : high while the fill is running
//   init_wen   : zero-write strobe into the storage array
//   init_waddr : address of the current zero write
module cm_sdp_ram_init_seq
  import cm_sdp_ram_pkg::*;
#(
  parameter int WIDTH_ADDR    = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  output logic                  init_busy,
  output logic                  init_wen,
  output logic [WIDTH_ADDR-1:0] init_waddr
);

  // One extra bit so the counter can never alias back to 0 on the last word.
  localparam logic [WIDTH_ADDR:0] LAST_ADDR = (WIDTH_ADDR+1)'(2**WIDTH_ADDR - 1);

  state_t                state_q, state_d;
  logic [WIDTH_ADDR:0]   init_addr_q, init_addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT_ON_RESET ? ST_INIT : ST_READY;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    if (clr) begin
      state_d     = ST_INIT;
      init_addr_d = '0;
    end else if (state_q == ST_INIT) begin
      if (init_addr_q == LAST_ADDR) begin
        state_d     = ST_READY;
        init_addr_d = '0;
      end else begin
        init_addr_d = init_addr_q + 1'b1;
      end
    end
  end

  assign init_busy  = (state_q == ST_INIT);
  assign init_wen   = init_busy;
  assign init_waddr = init_addr_q[WIDTH_ADDR-1:0];

endmodule

// File: rtl/cm_sdp_ram_resp.sv
// rtl/cm_sdp_ram_resp.sv - simple-dual-port RAM responder with zero-fill and write-first bypass
//
// Optional feature macro: CM_SDP_RAM_PARITY_EN (per-word even parity, par_inj / par_err ports)
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous clear, restarts zero-fill, beats port traffic
//   ram_wen/waddr/wdata : write port
//   ram_ren/raddr       : read port
//   ram_rdata           : registered read data, one cycle after ram_ren, held otherwise
//   init_busy           : high while zero-fill is running
//   par_inj             : (parity build) flip the stored parity bit of this write
//   par_err             : (parity build) pulse aligned with a ram_rdata whose parity is bad
module cm_sdp_ram_resp
  import cm_sdp_ram_pkg::*;
#(
  parameter int WIDTH_DATA    = 32,
  parameter int WIDTH_ADDR    = 4,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ram_wen,
  input  logic [WIDTH_DATA-1:0] ram_wdata,
  input  logic [WIDTH_ADDR-1:0] ram_waddr,
  input  logic                  ram_ren,
  input  logic [WIDTH_ADDR-1:0] ram_raddr,
  output logic [WIDTH_DATA-1:0] ram_rdata,
  output logic                  init_busy
`ifdef CM_SDP_RAM_PARITY_EN
  ,
  input  logic                  par_inj,
  output logic                  par_err
`endif
);

  localparam int DEPTH = 2**WIDTH_ADDR;
`ifdef CM_SDP_RAM_PARITY_EN
  localparam int WIDTH_MEM = WIDTH_DATA + 1;
`else
  localparam int WIDTH_MEM = WIDTH_DATA;
`endif

  logic [WIDTH_MEM-1:0]  mem [DEPTH];

  logic                  init_wen;
  logic [WIDTH_ADDR-1:0] init_waddr;

  logic                  port_ok;
  logic                  port_wen;
  logic                  port_ren;
  logic                  bypass;
  logic [WIDTH_MEM-1:0]  port_word;
  logic [WIDTH_MEM-1:0]  rd_word;
  logic [WIDTH_DATA-1:0] rd_data;

  logic                  mem_wen;
  logic [WIDTH_ADDR-1:0] mem_waddr;
  logic [WIDTH_MEM-1:0]  mem_wword;

  cm_sdp_ram_init_seq #(
    .WIDTH_ADDR    (WIDTH_ADDR),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .init_busy  (init_busy),
    .init_wen   (init_wen),
    .init_waddr (init_waddr)
  );

  // Port traffic is only honoured in READY and never in a clr cycle.
  assign port_ok  = ~init_busy & ~clr;
  assign port_wen = ram_wen & port_ok;
  assign port_ren = ram_ren & port_ok;
  assign bypass   = port_wen & port_ren & (ram_waddr == ram_raddr);

`ifdef CM_SDP_RAM_PARITY_EN
  assign port_word = {even_par(PAR_MAX_W'(ram_wdata), WIDTH_DATA) ^ par_inj, ram_wdata};
`else
  assign port_word = ram_wdata;
`endif

  assign rd_word = mem[ram_raddr];
  assign rd_data = rd_word[WIDTH_DATA-1:0];

  // The zero-fill owns the write port while it runs; zero data has zero parity.
  always_comb begin
    mem_wen   = port_wen;
    mem_waddr = ram_waddr;
    mem_wword = port_word;
    if (init_wen) begin
      mem_wen   = 1'b1;
      mem_waddr = init_waddr;
      mem_wword = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wen) mem[mem_waddr] <= mem_wword;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rdata <= '0;
    end else if (init_busy | clr) begin
      ram_rdata <= '0;
    end else if (port_ren) begin
      ram_rdata <= bypass ? ram_wdata : rd_data;
    end
  end

`ifdef CM_SDP_RAM_PARITY_EN
  // Bypassed data never touched storage, so it cannot carry a parity fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else begin
      par_err <= port_ren & ~bypass &
                 (rd_word[WIDTH_DATA] != even_par(PAR_MAX_W'(rd_data), WIDTH_DATA));
    end
  end
`endif

endmodule

// File: tb/tb_cm_sdp_ram_resp.sv
// tb/tb_cm_sdp_ram_resp.sv - scoreboard bench for cm_sdp_ram_resp
module tb_cm_sdp_ram_resp;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] rdata;
    logic        busy;
    logic        perr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        ram_wen = 1'b0;
  logic [31:0] ram_wdata = '0;
  logic [3:0]  ram_waddr = '0;
  logic        ram_ren = 1'b0;
  logic [3:0]  ram_raddr = '0;
  logic [31:0] ram_rdata;
  logic        init_busy;
`ifdef CM_SDP_RAM_PARITY_EN
  logic        par_inj = 1'b0;
  logic        par_err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        exp_q[$];
  int          init_left = DEPTH;
  logic [31:0] mem_m [DEPTH];
  logic        bad_m [DEPTH];
  logic [31:0] rdata_m = '0;

  cm_sdp_ram_resp #(
    .WIDTH_DATA    (32),
    .WIDTH_ADDR    (4),
    .INIT_ON_RESET (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .ram_wen   (ram_wen),
    .ram_wdata (ram_wdata),
    .ram_waddr (ram_waddr),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .init_busy (init_busy)
`ifdef CM_SDP_RAM_PARITY_EN
    ,
    .par_inj   (par_inj),
    .par_err   (par_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive at the falling edge, advance the reference
  // model across the following rising edge, and queue what must be seen after it.
  task automatic cyc(input logic r, input logic c, input logic we, input logic [3:0] wa,
                     input logic [31:0] wd, input logic re, input logic [3:0] ra,
                     input logic inj);
    exp_t e;
    logic perr_m;
    @(negedge clk);
    rst = r; clr = c; ram_wen = we; ram_waddr = wa; ram_wdata = wd;
    ram_ren = re; ram_raddr = ra;
`ifdef CM_SDP_RAM_PARITY_EN
    par_inj = inj;
`endif
    perr_m = 1'b0;
    if (r) begin
      init_left = DEPTH;
      rdata_m   = '0;
    end else if (c) begin
      init_left = DEPTH;
      rdata_m   = '0;
    end else if (init_left > 0) begin
      init_left--;
      rdata_m = '0;
      if (init_left == 0) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_m[i] = '0;
          bad_m[i] = 1'b0;
        end
      end
    end else begin
      if (re) begin
        if (we && wa == ra) begin
          rdata_m = wd;
        end else begin
          rdata_m = mem_m[ra];
          perr_m  = bad_m[ra];
        end
      end
      if (we) begin
        mem_m[wa] = wd;
        bad_m[wa] = inj;
      end
    end
    e.rdata = rdata_m;
    e.busy  = (init_left > 0);
    e.perr  = perr_m;
    exp_q.push_back(e);
    if (r) begin
      #1;
      chk("rst_async_rdata", ram_rdata, 32'h0);
      chk("rst_async_busy", {31'b0, init_busy}, 32'h1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'(a), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdata", ram_rdata, e.rdata);
        chk("init_busy", {31'b0, init_busy}, {31'b0, e.busy});
`ifdef CM_SDP_RAM_PARITY_EN
        chk("par_err", {31'b0, par_err}, {31'b0, e.perr});
`endif
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = 'x;
      bad_m[i] = 1'b0;
    end
    #1;
    chk("reset_rdata", ram_rdata, 32'h0);
    chk("reset_busy", {31'b0, init_busy}, 32'h1);

    // Reset, release, zero-fill, then every address reads back zero.
    repeat (3) cyc(1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 0);
    idle(18);
    read_all();

    // Plain write then read, then the value must hold without ram_ren.
    cyc(0, 0, 1, 4'h3, 32'hDEADBEEF, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h3, 0);
    idle(3);

    // Write-first bypass on a same-address collision.
    cyc(0, 0, 1, 4'h5, 32'h11, 0, 4'h0, 0);
    cyc(0, 0, 1, 4'h5, 32'h22, 1, 4'h5, 0);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h5, 0);

    // Fill everything, clear, restart the fill mid-way, writes during INIT are lost.
    for (int a = 0; a < DEPTH; a++) cyc(0, 0, 1, 4'(a), $urandom, 0, 4'h0, 0);
    cyc(0, 1, 1, 4'h1, 32'h5555, 1, 4'h1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 4'($urandom_range(0, 15)), $urandom, 1, 4'h0, 0);
    cyc(0, 1, 1, 4'h2, 32'h7777, 1, 4'h2, 0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 1, 4'($urandom_range(0, 15)), $urandom, 1, 4'h0, 0);
    read_all();

`ifdef CM_SDP_RAM_PARITY_EN
    cyc(0, 0, 1, 4'h2, 32'hA5, 0, 4'h0, 1);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h2, 0);
    idle(1);
    cyc(0, 0, 1, 4'h2, 32'hA5, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h2, 0);
    cyc(0, 0, 1, 4'h2, 32'hA5, 1, 4'h2, 1);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h2, 0);
    idle(1);
`endif

    // Randomised traffic with narrow addresses to force collisions and rare clears.
    for (int i = 0; i < 400; i++) begin
      cyc(0, ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    idle(DEPTH + 2);
    for (int i = 0; i < 200; i++) begin
      cyc(0, 1'b0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
          1'($urandom_range(0, 1)), 4'($urandom), ($urandom_range(0, 3) == 0));
    end

    // Reset in the middle of reads that return non-zero data.
    cyc(0, 0, 1, 4'h9, 32'hCAFEF00D, 0, 4'h0, 0);
    cyc(0, 0, 0, 4'h0, 32'h0, 1, 4'h9, 0);
    cyc(1, 0, 0, 4'h0, 32'h0, 1, 4'h9, 0);
    cyc(1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 0);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 4'h9, 32'h1234, 1, 4'h9, 0);
    read_all();

    idle(2);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cm_sdp_ram_resp.md
# cm_sdp_ram_resp

- Simple-dual-port RAM responder: the memory end of the FIFO controller RAM port bundle (`ram_wen/ram_wdata/ram_waddr/ram_ren/ram_raddr/ram_rdata`).
- Stores words written by the controller and returns read data one cycle after `ram_ren`, with write-first bypass on same-address collisions.
- Contains a zero-fill init sequencer started by reset or `clr`, so a cleared FIFO never exposes stale contents.
- Instantiated beside every controller-based sync FIFO in the datapath.

## Interface
Parameters:
- `WIDTH_DATA`, 32, word width
- `WIDTH_ADDR`, 4, address width; depth = 2**WIDTH_ADDR
- `INIT_ON_RESET`, 1, 1 = run zero-fill after reset release; 0 = go straight to READY

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clr`  in  1  synchronous clear; restarts zero-fill
- `ram_wen`  in  1  write strobe
- `ram_wdata`  in  WIDTH_DATA  write data
- `ram_waddr`  in  WIDTH_ADDR  write address
- `ram_ren`  in  1  read strobe
- `ram_raddr`  in  WIDTH_ADDR  read address
- `ram_rdata`  out  WIDTH_DATA  registered read data
- `init_busy`  out  1  high while zero-fill is running
- `par_inj`  in  1  present only with the parity macro; inverts the stored parity bit of the current write
- `par_err`  out  1  present only with the parity macro; one-cycle pulse aligned with a bad `ram_rdata`

## Operation
States:
- INIT: write zero to `init_addr`, then increment it. At `init_addr == 2**WIDTH_ADDR-1`, write that last word and go to READY.
- READY: serve ports.

Transitions:
- Reset: state = INIT if `INIT_ON_RESET`, else READY; `init_addr` = 0.
- `clr` in any state: state = INIT, `init_addr` = 0. `clr` during INIT restarts from 0.
- `clr` has priority over port traffic in the same cycle.

While in INIT:
- `ram_wen` and `ram_ren` are ignored.
- `ram_rdata` is driven 0.

In READY:
- Write: if `ram_wen`, then `mem[ram_waddr] <= ram_wdata`.
- Read: if `ram_ren`, then `ram_rdata <= mem[ram_raddr]`.
- Collision: `ram_wen & ram_ren` with `ram_waddr == ram_raddr` returns `ram_wdata` (write-first bypass).
- Without `ram_ren`, `ram_rdata` holds its previous value.

Reset values:
- `ram_rdata` = 0
- `init_busy` = `INIT_ON_RESET`
- `par_err` = 0
- Memory contents are not reset; they are defined only after INIT completes.

## Timing
- Read latency: exactly 1 cycle. `ram_ren` sampled at edge N makes `ram_rdata` valid after edge N and held until the next accepted read.
- Write-to-read: a write at edge N is visible to a read at edge N (bypass) or at any later edge.
- Zero-fill duration: 2**WIDTH_ADDR cycles from the first INIT cycle. `init_busy` deasserts on the same edge the state enters READY.
- Asserting `rst` mid-operation immediately forces the reset values. Zero-fill restarts after release when `INIT_ON_RESET = 1`.
- `init_addr` is WIDTH_ADDR+1 bits internally; only the low WIDTH_ADDR bits address memory. No wrap occurs because the last address ends INIT.

## Configuration
Macro: `CM_SDP_RAM_PARITY_EN`.

Defined:
- Each word is stored as WIDTH_DATA+1 bits, the extra bit being even parity of the data.
- `par_inj` high during a write inverts the stored parity bit.
- On read, parity is recomputed; `par_err` pulses high for the cycle `ram_rdata` is valid if it mismatches.
- A bypassed read always has correct parity.
- INIT writes the correct parity for zero, which is 0.

Not defined:
- `par_inj` and `par_err` ports are absent.
- Storage is WIDTH_DATA bits.
- Behaviour is otherwise identical.

## Structure
Package `cm_sdp_ram_pkg` holds:
- the state encoding constants (INIT, READY)
- the even-parity function, parameterised by width

Sub-module `cm_sdp_ram_init_seq` holds:
- the state register and `init_addr` counter
- outputs `init_busy`, `init_wen`, `init_waddr`

The top level muxes the init write ahead of the port write and owns the storage array and read register.

## Test plan
- Reset with `INIT_ON_RESET=1`, WIDTH_ADDR=4 -> `init_busy` high for exactly 16 cycles after release; afterwards reads of addresses 0..15 all return 0.
- Write 0xDEADBEEF to addr 3; read addr 3 the next cycle -> `ram_rdata` = 0xDEADBEEF one cycle after `ram_ren`. Deassert `ram_ren` -> value holds.
- Memory holds 0x11 at addr 5; write 0x22 to addr 5 and read addr 5 in the same cycle -> `ram_rdata` = 0x22 (bypass).
- Fill all 16 addresses; pulse `clr` at INIT cycle 7 of the ensuing fill -> count restarts, `init_busy` stays high 16 more cycles. Writes issued during INIT are discarded; all addresses read 0 afterwards.
- Assert `rst` mid-read -> `ram_rdata` = 0 immediately; INIT reruns on release.
- With `CM_SDP_RAM_PARITY_EN`: write 0xA5 to addr 2 with `par_inj=1`, then read addr 2 -> `par_err` pulses 1 cycle with `ram_rdata` = 0xA5. Same write with `par_inj=0` -> no pulse. A bypassed read with an injected error -> no pulse.
